// File: rtl/vec_rr_arbiter.sv
// Packet-granular round-robin arbiter that funnels req_p vector requesters
// into one registered valid/ready output stage tagged with the source id.
module vec_rr_arbiter #(
  parameter int unsigned width_p = 8,
  parameter int unsigned depth_p = 8,
  parameter int unsigned req_p   = 4,
  parameter int unsigned id_w_p  = $clog2(req_p)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [req_p-1:0][depth_p-1:0][width_p-1:0] data_i,
  input  logic [req_p-1:0]                          valid_i,
  input  logic [req_p-1:0]                          last_i,
  output logic [req_p-1:0]                          ready_o,
  output logic                                      valid_o,
  output logic [depth_p-1:0][width_p-1:0]           data_o,
  output logic                                      last_o,
  output logic [id_w_p-1:0]                         id_o,
  input  logic                                      ready_i
);

  localparam logic StIdle   = 1'b0;
  localparam logic StLocked = 1'b1;

  logic                            state_q, state_d;
  logic [id_w_p-1:0]               owner_q, owner_d;
  logic [id_w_p-1:0]               rr_ptr_q, rr_ptr_d;
  logic                            valid_q, valid_d;
  logic [depth_p-1:0][width_p-1:0] data_q, data_d;
  logic                            last_q, last_d;
  logic [id_w_p-1:0]               id_q, id_d;

  logic                            load_c;
  logic                            scan_hit_c;
  logic [id_w_p-1:0]               scan_g_c;
  logic [id_w_p-1:0]               cand_c;
  logic [id_w_p-1:0]               grant_c;
  logic                            grant_valid_c;
  logic                            accept_c;
  int                              scan_j;

  // First valid requester at or after rr_ptr, wrapping modulo req_p.
  always_comb begin
    scan_hit_c = 1'b0;
    scan_g_c   = '0;
    cand_c     = '0;
    scan_j     = 0;
    for (int k = 0; k < int'(req_p); k++) begin
      scan_j = (int'(rr_ptr_q) + k) % int'(req_p);
      cand_c = id_w_p'(scan_j);
      if (!scan_hit_c && valid_i[cand_c]) begin
        scan_hit_c = 1'b1;
        scan_g_c   = cand_c;
      end
    end
  end

  // Grant, handshake and next-state; a locked owner keeps the port even when idle.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    id_d     = id_q;
    ready_o  = '0;

    load_c = ~valid_q | ready_i;
    if (state_q == StLocked) begin
      grant_c       = owner_q;
      grant_valid_c = 1'b1;
    end else begin
      grant_c       = scan_g_c;
      grant_valid_c = scan_hit_c;
    end
    accept_c = load_c & grant_valid_c & valid_i[grant_c];

    if (load_c && grant_valid_c) begin
      ready_o[grant_c] = 1'b1;
    end

    if (accept_c) begin
      valid_d = 1'b1;
      data_d  = data_i[grant_c];
      last_d  = last_i[grant_c];
      id_d    = grant_c;
      if (last_i[grant_c]) begin
        state_d  = StIdle;
        rr_ptr_d = (grant_c == id_w_p'(req_p - 1)) ? '0 : grant_c + id_w_p'(1);
      end else begin
        state_d = StLocked;
        owner_d = grant_c;
      end
    end else if (load_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      id_q     <= id_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign id_o    = id_q;

endmodule

// File: tb/tb_vec_rr_arbiter.sv
// Self-checking bench for vec_rr_arbiter: directed scenarios plus random
// traffic, all compared against a packet-level round-robin reference model.
module tb_vec_rr_arbiter;

  localparam int REQ = 4;
  localparam int DEP = 8;
  localparam int W   = 8;

  logic                          clk_i = 1'b0;
  logic                          rst_ni;
  logic [REQ-1:0][DEP-1:0][W-1:0] data_i;
  logic [REQ-1:0]                valid_i;
  logic [REQ-1:0]                last_i;
  logic [REQ-1:0]                ready_o;
  logic                          valid_o;
  logic [DEP-1:0][W-1:0]         data_o;
  logic                          last_o;
  logic [1:0]                    id_o;
  logic                          ready_i;

  always #5 clk_i = ~clk_i;

  vec_rr_arbiter #(
    .width_p(W), .depth_p(DEP), .req_p(REQ), .id_w_p(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
    .last_o(last_o), .id_o(id_o), .ready_i(ready_i)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: output register contents plus arbitration bookkeeping.
  bit                    m_valid;
  bit                    m_last;
  bit                    m_locked;
  int                    m_id;
  int                    m_ptr;
  int                    m_owner;
  logic [DEP-1:0][W-1:0] m_data;
  int                    last_acc;
  int                    obs_id;

  function automatic logic [DEP-1:0][W-1:0] rand_vec();
    logic [DEP-1:0][W-1:0] v;
    for (int l = 0; l < DEP; l++) v[l] = W'($urandom);
    return v;
  endfunction

  function automatic int exp_grant();
    if (m_locked) return m_owner;
    for (int k = 0; k < REQ; k++) begin
      int j;
      j = (m_ptr + k) % REQ;
      if (valid_i[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_locked = 1'b0;
    m_id     = 0;
    m_ptr    = 0;
    m_owner  = 0;
    m_data   = '0;
  endtask

  // One clock: check ready_o before the edge, advance model, check outputs after.
  task automatic cycle(input string tag);
    int                             g;
    bit                             load;
    logic [REQ-1:0]                 er;
    logic [REQ-1:0]                 vi;
    logic [REQ-1:0]                 li;
    logic [REQ-1:0][DEP-1:0][W-1:0] di;
    #1;
    load = !m_valid || ready_i;
    g    = exp_grant();
    er   = '0;
    if (load && g >= 0) er[g] = 1'b1;
    tests_run++;
    if (ready_o !== er) begin
      tests_failed++;
      $display("FAIL %s ready_o got %b want %b", tag, ready_o, er);
    end
    vi = valid_i;
    li = last_i;
    di = data_i;
    @(posedge clk_i);
    last_acc = -1;
    if (load) begin
      if (g >= 0 && vi[g]) begin
        m_valid  = 1'b1;
        m_data   = di[g];
        m_last   = li[g];
        m_id     = g;
        last_acc = g;
        if (li[g]) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % REQ;
        end else begin
          m_locked = 1'b1;
          m_owner  = g;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    tests_run++;
    if (valid_o !== m_valid) begin
      tests_failed++;
      $display("FAIL %s valid_o got %b want %b", tag, valid_o, m_valid);
    end
    if (m_valid) begin
      tests_run++;
      if (id_o !== 2'(m_id) || last_o !== m_last || data_o !== m_data) begin
        tests_failed++;
        $display("FAIL %s beat got id=%0d last=%b data=%h want id=%0d last=%b data=%h",
                 tag, id_o, last_o, data_o, m_id, m_last, m_data);
      end
    end
    obs_id = (valid_o === 1'b1) ? int'(id_o) : -1;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    valid_i = '0;
    last_i  = '0;
    data_i  = '0;
    ready_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    tests_run++;
    if (valid_o !== 1'b0 || last_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset valid/last got %b/%b want 0/0", valid_o, last_o);
    end
    tests_run++;
    if (id_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset id_o got %0d want 0", id_o);
    end
    tests_run++;
    if (data_o !== '0) begin
      tests_failed++;
      $display("FAIL reset data_o got %h want 0", data_o);
    end
    tests_run++;
    if (ready_o !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset ready_o got %b want 0000", ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle("idle");
      tests_run++;
      if (obs_id != -1) begin
        tests_failed++;
        $display("FAIL idle output got id %0d want none", obs_id);
      end
    end
  endtask

  task automatic test_round_robin();
    valid_i = '1;
    last_i  = '1;
    for (int i = 0; i < REQ; i++) data_i[i] = rand_vec();
    for (int k = 0; k < 6; k++) begin
      cycle("rr");
      tests_run++;
      if (obs_id != k % 4) begin
        tests_failed++;
        $display("FAIL rr_order beat %0d got id %0d want %0d", k, obs_id, k % 4);
      end
      if (last_acc >= 0) data_i[last_acc] = rand_vec();
    end
    valid_i = '0;
    cycle("rr_drain");
  endtask

  task automatic test_locked_packet();
    logic [REQ-1:0] vtab [8];
    logic           l1tab [8];
    int             etab [8];
    vtab  = '{4'b0001, 4'b0111, 4'b0111, 4'b0101, 4'b0101, 4'b0111, 4'b0101, 4'b0101};
    l1tab = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    etab  = '{0, 1, 1, -1, -1, 1, 2, 0};
    for (int i = 0; i < REQ; i++) data_i[i] = rand_vec();
    for (int k = 0; k < 8; k++) begin
      valid_i = vtab[k];
      last_i  = {1'b0, 1'b1, l1tab[k], 1'b1};
      cycle("lock");
      tests_run++;
      if (obs_id != etab[k]) begin
        tests_failed++;
        $display("FAIL lock_order step %0d got id %0d want %0d", k, obs_id, etab[k]);
      end
      if (last_acc >= 0) data_i[last_acc] = rand_vec();
    end
    valid_i = '0;
    cycle("lock_drain");
  endtask

  task automatic test_stall();
    valid_i = '1;
    last_i  = '1;
    ready_i = 1'b1;
    for (int i = 0; i < REQ; i++) data_i[i] = rand_vec();
    cycle("stall_pre");
    tests_run++;
    if (obs_id != 1) begin
      tests_failed++;
      $display("FAIL stall_pre got id %0d want 1", obs_id);
    end
    if (last_acc >= 0) data_i[last_acc] = rand_vec();
    ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle("stall");
      tests_run++;
      if (obs_id != 1 || ready_o !== 4'b0000) begin
        tests_failed++;
        $display("FAIL stall_hold got id %0d ready %b want id 1 ready 0000", obs_id, ready_o);
      end
    end
    ready_i = 1'b1;
    cycle("stall_release");
    tests_run++;
    if (obs_id != 2) begin
      tests_failed++;
      $display("FAIL stall_release got id %0d want 2", obs_id);
    end
    valid_i = '0;
    cycle("stall_drain");
  endtask

  task automatic test_signed_extremes();
    logic [DEP-1:0][W-1:0] v;
    for (int l = 0; l < DEP; l++) v[l] = (l % 2 == 1) ? 8'h7F : 8'h80;
    data_i[3] = v;
    valid_i   = 4'b1000;
    last_i    = 4'b1000;
    cycle("signed");
    tests_run++;
    if (obs_id != 3 || data_o !== v) begin
      tests_failed++;
      $display("FAIL signed got id %0d data %h want id 3 data %h", obs_id, data_o, v);
    end
    valid_i = '0;
    cycle("signed_drain");
  endtask

  task automatic test_async_reset();
    valid_i   = 4'b1000;
    last_i    = 4'b0000;
    data_i[3] = rand_vec();
    cycle("lock3");
    tests_run++;
    if (obs_id != 3) begin
      tests_failed++;
      $display("FAIL lock3 got id %0d want 3", obs_id);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset valid_o got %b want 0", valid_o);
    end
    valid_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    valid_i = '1;
    last_i  = '1;
    for (int i = 0; i < REQ; i++) data_i[i] = rand_vec();
    cycle("post_reset");
    tests_run++;
    if (obs_id != 0) begin
      tests_failed++;
      $display("FAIL post_reset got id %0d want 0", obs_id);
    end
    valid_i = '0;
    cycle("post_reset_drain");
  endtask

  task automatic test_random();
    valid_i = '0;
    for (int n = 0; n < 400; n++) begin
      ready_i = ($urandom % 4) != 0;
      for (int i = 0; i < REQ; i++) begin
        if (!valid_i[i] && ($urandom % 2) == 1) begin
          valid_i[i] = 1'b1;
          last_i[i]  = ($urandom % 3) == 0;
          data_i[i]  = rand_vec();
        end
      end
      cycle("rand");
      if (last_acc >= 0) valid_i[last_acc] = 1'b0;
    end
    valid_i = '0;
    ready_i = 1'b1;
    cycle("rand_drain");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_locked_packet();
    test_stall();
    test_signed_extremes();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vec_rr_arbiter.md
Name: vec_rr_arbiter

Overview:
- Shares one registered elastic vector stage between req_p upstream requesters, e.g. activation/weight feeders competing for a single systolic-array input port.
- Round-robin arbitration at packet granularity: a packet is one or more beats, terminated by last.
- Output is a registered valid/ready stage that carries the winning vector, its last flag and the source id.

Parameters:
- width_p, 8, bits per signed lane.
- depth_p, 8, lanes per vector.
- req_p, 4, number of requesters; legal range 2..16.
- id_w_p, $clog2(req_p), width of the source id.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- data_i  in  signed [width_p-1:0] x [req_p][depth_p]  per-requester vector.
- valid_i  in  [req_p]  per-requester beat valid.
- last_i  in  [req_p]  final beat of the packet.
- ready_o  out  [req_p]  per-requester beat accept.
- valid_o  out  1  output beat valid.
- data_o  out  signed [width_p-1:0] x [depth_p]  output vector.
- last_o  out  1  last flag of the output beat.
- id_o  out  id_w_p  index of the requester that sourced the output beat.
- ready_i  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync release): valid_o=0, data_o all 0, last_o=0, id_o=0, state=IDLE, rr_ptr=0.
- Load condition: load = ~valid_o | ready_i.
  - Downstream transfer occurs when valid_o & ready_i.
  - While valid_o=1 and ready_i=0, data_o, last_o and id_o hold stable.
- Grant g is computed combinationally each cycle.
  - ready_o[i] = load & (i==g) & grant_valid.
  - At most one ready_o bit is high in any cycle.
  - A beat is accepted when valid_i[g] & ready_o[g].
- On an accepted beat, at the next edge: data_o<=data_i[g], last_o<=last_i[g], id_o<=g, valid_o<=1.
- When load=1 and no beat is accepted, valid_o<=0 at the next edge. data_o is not required to clear.
- Latency: 1 cycle from acceptance to valid_o. Full throughput is 1 beat/cycle when ready_i=1.
- State IDLE:
  - g = first i with valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ... mod req_p.
  - grant_valid = |valid_i.
  - Accepted beat with last=1: stay IDLE, rr_ptr<=(g+1) mod req_p.
  - Accepted beat with last=0: go to LOCKED, owner<=g.
- State LOCKED:
  - g=owner and grant_valid=1 regardless of the other requesters.
  - If valid_i[owner]=0, the cycle is a bubble: no other requester is served and ready_o[owner] may be high.
  - Accepted beat with last=1: go to IDLE, rr_ptr<=(owner+1) mod req_p.
- rr_ptr and state change only on accepted beats, never on stalls.
- A requester must hold data_i, valid_i and last_i stable until accepted.
- Downstream stall (load=0): all ready_o=0, and state and pointer are frozen.
- Simultaneous downstream transfer and new accept in the same cycle: the output register is overwritten with the new beat, with no bubble.
- Single requester: it is granted every cycle with no idle cycles inserted.
- rr_ptr wrap: rr_ptr advances from req_p-1 to 0.
- Reset mid-packet clears the lock and any pending output beat. Upstream requesters must also be reset.
- Data passes through unmodified; there is no arithmetic on lanes.

Test Plan:
- Reset → valid_o=0, id_o=0, data_o=0, ready_o=0000. Then valid_i=0000 for 5 cycles with ready_i=1 → valid_o remains 0.
- All 4 requesters valid with single-beat packets (last=1), ready_i=1 → id_o sequence 0,1,2,3,0,1; one beat per cycle; data_o matches the lane values of the corresponding source.
- Req1 sends a 3-beat packet (last on beat 3) while req0 and req2 are continuously valid → id_o=1,1,1 contiguous, then 2, then 0. Req1 drops valid for 2 cycles mid-packet → 2 bubble cycles on valid_o and no other grants.
- ready_i held 0 for 4 cycles with valid_o=1 → data_o, id_o and last_o are unchanged, ready_o=0000, and rr_ptr is unchanged. On ready_i=1, the next beat loads in the same cycle as the transfer.
- Signed extremes: lanes set to -128 and 127 with width_p=8 → data_o reproduces them bit-exact.
- rst_ni asserted asynchronously mid-cycle while LOCKED on req3 → valid_o drops immediately. After release, req0 wins first when all are valid.
